json_frame_ctrl: RTL and testbench
==================================

Name: json_frame_ctrl

Overview:
- Streaming structural controller for the JSON decode path. Consumes one byte per cycle of a framed JSON text.
- Tracks string and escape context plus a container nesting stack (object/array).
- Reports one result per frame: error kind, first-error byte position and maximum depth. Error kinds mirror the decoder's error taxonomy.
- Sits in front of the token/value datapath and gates it: the datapath consumes only frames this block reports as structurally valid.

Parameters:
- MAX_DEPTH, 32, stack entries (max nesting depth); at least 1.
- DEPTH_W, $clog2(MAX_DEPTH+1), width of depth outputs.
- POS_W, 16, width of byte-position counter; saturates at all-ones.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input byte valid.
- s_ready  out  1  block accepts byte; transfer when s_valid&&s_ready.
- s_data  in  8  JSON byte.
- s_last  in  1  final byte of frame.
- depth  out  DEPTH_W  current nesting depth.
- res_valid  out  1  one-cycle result pulse.
- res_err  out  3  0 OK, 1 EOI, 2 UNEXPECTED_TOKEN, 3 TRAILING, 4 DEPTH_OVERFLOW, 5 INVALID_CHAR, 6 INVALID_ESCAPE, 7 NOT_CONTAINER.
- res_pos  out  POS_W  0-based index of the first offending byte; for OK/EOI, the index of the last byte.
- res_max_depth  out  DEPTH_W  deepest nesting reached in the frame.

Behaviour:
- Reset: state=IDLE, depth=0, stack cleared, pos=0, res_valid=0, res_err=0, res_pos=0, res_max_depth=0, s_ready=0.
- s_ready=1 in every state except RESULT. Reset mid-frame discards the frame and produces no result.
- Whitespace is 0x20, 0x09, 0x0A, 0x0D.
- FSM states: IDLE, STRUCT, STRING, ESCAPE, UHEX (feature only), TAIL, DRAIN, RESULT.
- IDLE:
  - Whitespace is ignored.
  - '{' or '[' pushes the container kind (1=object, 0=array) and goes to STRUCT.
  - Any other byte raises NOT_CONTAINER.
- STRUCT:
  - '{' or '[' pushes; a push when depth==MAX_DEPTH raises DEPTH_OVERFLOW and leaves the stack unchanged.
  - '}' pops if top==object, else UNEXPECTED_TOKEN. ']' pops if top==array, else UNEXPECTED_TOKEN.
  - A pop to depth 0 goes to TAIL.
  - '"' goes to STRING. All other bytes are accepted unchecked (scalars, ':' and ',').
- STRING: '\' goes to ESCAPE; '"' goes to STRUCT; a byte < 0x20 raises INVALID_CHAR.
- ESCAPE: any byte returns to STRING (base build).
- TAIL: whitespace is ignored; any other byte raises TRAILING.
- Errors record res_err and res_pos at the first error only. Afterwards the FSM goes to DRAIN, which accepts and discards bytes until s_last.
- s_last handling:
  - Evaluated after processing the byte.
  - An error on the last byte is reported directly, with no DRAIN.
  - Frame ending in IDLE, STRUCT, STRING, ESCAPE or UHEX gives EOI. Frame ending in TAIL gives OK.
- RESULT: entered the cycle after the last byte's handshake. s_ready=0. res_valid=1 for exactly 1 cycle, then IDLE with depth, stack, pos and max depth cleared.
- res_err, res_pos and res_max_depth hold until the next result. res_max_depth updates on each push, using post-push depth.
- depth updates the cycle after the push/pop byte.
- Position counter increments per accepted byte and saturates at 2^POS_W-1; res_pos reports the saturated value.
- Latency: result pulse 1 cycle after the last-byte handshake. Throughput: 1 byte/cycle, plus 1 bubble cycle per frame.

Optional Feature:
- Macro: JSON_ESCAPE_CHECK_EN.
- Defined:
  - ESCAPE accepts only " \ / b f n r t; anything else raises INVALID_ESCAPE.
  - 'u' goes to UHEX, which requires exactly 4 bytes from [0-9A-Fa-f] (2-bit counter) and then returns to STRING.
  - A non-hex byte raises INVALID_ESCAPE at that byte.
- Undefined: UHEX does not exist, ESCAPE accepts any byte, and code 6 is never produced.

Test Plan:
- `{"a":[1,2]}` then s_last on '}' -> res_valid 1 cycle later, res_err=0, res_pos=10, res_max_depth=2, depth back to 0.
- `[1}` with last on '}' -> res_err=2, res_pos=2; `{"x" ` with last on the space -> res_err=1, res_pos=4.
- MAX_DEPTH=4, input `[[[[[` then 3 bytes of filler with last -> res_err=4, res_pos=4. DRAIN holds s_ready=1; result pulses after the last byte.
- `{}  x` -> res_err=3, res_pos=4; `  7` -> res_err=7, res_pos=2; `["a<0x01>"]` -> res_err=5, res_pos=3.
- With JSON_ESCAPE_CHECK_EN:
  - `["\q"]` -> res_err=6, res_pos=3.
  - `["\u00eG"]` -> res_err=6, res_pos=7.
  - `["\u00e9"]` -> OK.
  - Without the macro, `["\q"]` -> OK.
- Assert rst_n low mid-frame after `{{` -> depth=0 and no res_valid. Next frame `[]` -> OK, res_pos=1, res_max_depth=1. Back-to-back frames with s_valid held high -> exactly one s_ready=0 bubble per frame.

Source files
------------

// File: rtl/json_frame_ctrl.sv
// json_frame_ctrl: streaming structural checker for framed JSON text.
// Tracks string/escape context and an object/array nesting stack, then
// emits one result per frame (error kind, first-error position, max depth).
// Optional feature macro: JSON_ESCAPE_CHECK_EN (strict escape validation,
// including \uXXXX hex digits). Without it, any byte after '\' is accepted.
module json_frame_ctrl #(
    parameter int MAX_DEPTH = 32,
    parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1),
    parameter int POS_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [7:0]         s_data,
    input  logic               s_last,
    output logic [DEPTH_W-1:0] depth,
    output logic               res_valid,
    output logic [2:0]         res_err,
    output logic [POS_W-1:0]   res_pos,
    output logic [DEPTH_W-1:0] res_max_depth
);
    localparam logic [2:0] E_OK       = 3'd0;
    localparam logic [2:0] E_EOI      = 3'd1;
    localparam logic [2:0] E_UNEXP    = 3'd2;
    localparam logic [2:0] E_TRAIL    = 3'd3;
    localparam logic [2:0] E_OVF      = 3'd4;
    localparam logic [2:0] E_BAD_CHAR = 3'd5;
`ifdef JSON_ESCAPE_CHECK_EN
    localparam logic [2:0] E_BAD_ESC  = 3'd6;
`endif
    localparam logic [2:0] E_NOT_CONT = 3'd7;

    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(MAX_DEPTH);
    localparam logic [POS_W-1:0]   POS_SAT    = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STRUCT,
        S_STRING,
        S_ESCAPE,
`ifdef JSON_ESCAPE_CHECK_EN
        S_UHEX,
`endif
        S_TAIL,
        S_DRAIN,
        S_RESULT
    } state_t;

    state_t             state_q, state_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    // Shift-register stack: bit 0 is the top (1 = object, 0 = array).
    // One spare bit above MAX_DEPTH keeps the slices legal when MAX_DEPTH == 1.
    logic [MAX_DEPTH:0] stack_q, stack_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [DEPTH_W-1:0] max_q, max_d;
    logic [2:0]         err_q, err_d;
    logic [POS_W-1:0]   err_pos_q, err_pos_d;
    logic               s_ready_q;
    logic               res_valid_q, res_valid_d;
    logic [2:0]         res_err_q, res_err_d;
    logic [POS_W-1:0]   res_pos_q, res_pos_d;
    logic [DEPTH_W-1:0] res_max_q, res_max_d;
`ifdef JSON_ESCAPE_CHECK_EN
    logic [1:0]         hex_cnt_q, hex_cnt_d;
    logic               is_hex;
`endif

    logic               accept, is_ws, is_open, do_push, do_pop, fault;
    logic [2:0]         fault_code;
    logic [DEPTH_W-1:0] depth_inc;

    assign accept    = s_valid && s_ready_q;
    assign is_ws     = (s_data == 8'h20) || (s_data == 8'h09) ||
                       (s_data == 8'h0A) || (s_data == 8'h0D);
    assign is_open   = (s_data == 8'h7B) || (s_data == 8'h5B);
    assign depth_inc = depth_q + DEPTH_W'(1);
`ifdef JSON_ESCAPE_CHECK_EN
    assign is_hex    = ((s_data >= 8'h30) && (s_data <= 8'h39)) ||
                       ((s_data >= 8'h41) && (s_data <= 8'h46)) ||
                       ((s_data >= 8'h61) && (s_data <= 8'h66));
`endif

    // Next-state logic: classify the accepted byte, update stack and result.
    always_comb begin
        state_d     = state_q;
        depth_d     = depth_q;
        stack_d     = stack_q;
        pos_d       = pos_q;
        max_d       = max_q;
        err_d       = err_q;
        err_pos_d   = err_pos_q;
        res_valid_d = 1'b0;
        res_err_d   = res_err_q;
        res_pos_d   = res_pos_q;
        res_max_d   = res_max_q;
        do_push     = 1'b0;
        do_pop      = 1'b0;
        fault       = 1'b0;
        fault_code  = E_OK;
`ifdef JSON_ESCAPE_CHECK_EN
        hex_cnt_d   = hex_cnt_q;
`endif
        if (state_q == S_RESULT) begin
            // Bubble cycle after a result: clear all per-frame context.
            state_d   = S_IDLE;
            depth_d   = '0;
            stack_d   = '0;
            pos_d     = '0;
            max_d     = '0;
            err_d     = E_OK;
            err_pos_d = '0;
        end else if (accept) begin
            pos_d = (pos_q == POS_SAT) ? pos_q : pos_q + POS_W'(1);
            case (state_q)
                S_IDLE: begin
                    if (is_open) begin
                        do_push = 1'b1;
                    end else if (!is_ws) begin
                        fault      = 1'b1;
                        fault_code = E_NOT_CONT;
                    end
                end
                S_STRUCT: begin
                    if (is_open) begin
                        do_push = 1'b1;
                    end else if (s_data == 8'h7D || s_data == 8'h5D) begin
                        // '}' must close an object, ']' an array
                        if (stack_q[0] == (s_data == 8'h7D)) begin
                            do_pop = 1'b1;
                        end else begin
                            fault      = 1'b1;
                            fault_code = E_UNEXP;
                        end
                    end else if (s_data == 8'h22) begin
                        state_d = S_STRING;
                    end
                end
                S_STRING: begin
                    if (s_data == 8'h5C) begin
                        state_d = S_ESCAPE;
                    end else if (s_data == 8'h22) begin
                        state_d = S_STRUCT;
                    end else if (s_data < 8'h20) begin
                        fault      = 1'b1;
                        fault_code = E_BAD_CHAR;
                    end
                end
                S_ESCAPE: begin
`ifdef JSON_ESCAPE_CHECK_EN
                    case (s_data)
                        8'h22, 8'h5C, 8'h2F, 8'h62, 8'h66, 8'h6E, 8'h72, 8'h74:
                            state_d = S_STRING;
                        8'h75: begin
                            state_d   = S_UHEX;
                            hex_cnt_d = 2'd0;
                        end
                        default: begin
                            fault      = 1'b1;
                            fault_code = E_BAD_ESC;
                        end
                    endcase
`else
                    state_d = S_STRING;
`endif
                end
`ifdef JSON_ESCAPE_CHECK_EN
                S_UHEX: begin
                    if (!is_hex) begin
                        fault      = 1'b1;
                        fault_code = E_BAD_ESC;
                    end else if (hex_cnt_q == 2'd3) begin
                        state_d = S_STRING;
                    end else begin
                        hex_cnt_d = hex_cnt_q + 2'd1;
                    end
                end
`endif
                S_TAIL: begin
                    if (!is_ws) begin
                        fault      = 1'b1;
                        fault_code = E_TRAIL;
                    end
                end
                default: ; // DRAIN discards bytes until the frame ends
            endcase

            if (do_push) begin
                if (depth_q == DEPTH_FULL) begin
                    fault      = 1'b1;
                    fault_code = E_OVF;
                end else begin
                    stack_d = {stack_q[MAX_DEPTH-1:0], (s_data == 8'h7B)};
                    depth_d = depth_inc;
                    if (depth_inc > max_q) max_d = depth_inc;
                    state_d = S_STRUCT;
                end
            end
            if (do_pop) begin
                stack_d = {1'b0, stack_q[MAX_DEPTH:1]};
                depth_d = depth_q - DEPTH_W'(1);
                if (depth_q == DEPTH_W'(1)) state_d = S_TAIL;
            end
            if (fault) begin
                err_d     = fault_code;
                err_pos_d = pos_q;
                state_d   = S_DRAIN;
            end
            if (s_last) begin
                res_valid_d = 1'b1;
                res_max_d   = max_d;
                if (fault) begin
                    res_err_d = fault_code;
                    res_pos_d = pos_q;
                end else if (state_q == S_DRAIN) begin
                    res_err_d = err_q;
                    res_pos_d = err_pos_q;
                end else begin
                    res_err_d = (state_d == S_TAIL) ? E_OK : E_EOI;
                    res_pos_d = pos_q;
                end
                state_d = S_RESULT;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            depth_q     <= '0;
            stack_q     <= '0;
            pos_q       <= '0;
            max_q       <= '0;
            err_q       <= E_OK;
            err_pos_q   <= '0;
            s_ready_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_err_q   <= E_OK;
            res_pos_q   <= '0;
            res_max_q   <= '0;
`ifdef JSON_ESCAPE_CHECK_EN
            hex_cnt_q   <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            depth_q     <= depth_d;
            stack_q     <= stack_d;
            pos_q       <= pos_d;
            max_q       <= max_d;
            err_q       <= err_d;
            err_pos_q   <= err_pos_d;
            s_ready_q   <= (state_d != S_RESULT);
            res_valid_q <= res_valid_d;
            res_err_q   <= res_err_d;
            res_pos_q   <= res_pos_d;
            res_max_q   <= res_max_d;
`ifdef JSON_ESCAPE_CHECK_EN
            hex_cnt_q   <= hex_cnt_d;
`endif
        end
    end

    assign s_ready       = s_ready_q;
    assign depth         = depth_q;
    assign res_valid     = res_valid_q;
    assign res_err       = res_err_q;
    assign res_pos       = res_pos_q;
    assign res_max_depth = res_max_q;

endmodule

// File: tb/tb_json_frame_ctrl.sv
// Testbench for json_frame_ctrl: directed frames plus random frames checked
// against a queue-based reference scanner. Honours JSON_ESCAPE_CHECK_EN.
module tb_json_frame_ctrl;
    localparam int MAX_DEPTH = 4;
    localparam int DEPTH_W   = $clog2(MAX_DEPTH + 1);
    localparam int POS_W     = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               s_valid;
    logic               s_ready;
    logic [7:0]         s_data;
    logic               s_last;
    logic [DEPTH_W-1:0] depth;
    logic               res_valid;
    logic [2:0]         res_err;
    logic [POS_W-1:0]   res_pos;
    logic [DEPTH_W-1:0] res_max_depth;

    int err_cnt    = 0;
    int chk_cnt    = 0;
    int pulse_cnt  = 0;
    int exp_pulses = 0;
    bit pending_bubble = 1'b0;

    json_frame_ctrl #(.MAX_DEPTH(MAX_DEPTH), .POS_W(POS_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .s_last        (s_last),
        .depth         (depth),
        .res_valid     (res_valid),
        .res_err       (res_err),
        .res_pos       (res_pos),
        .res_max_depth (res_max_depth)
    );

    always #5 clk = ~clk;

    // Count every result pulse seen, to catch spurious or missing pulses.
    always @(negedge clk) if (res_valid) pulse_cnt++;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        chk_cnt++;
        if (got != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void str2q(input string s, output byte unsigned q[$]);
        q = {};
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    endfunction

    function automatic bit is_hex(input byte unsigned c);
        return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
               (c >= 8'h61 && c <= 8'h66);
    endfunction

    function automatic bit is_simple_esc(input byte unsigned c);
        case (c)
            8'h22, 8'h5C, 8'h2F, 8'h62, 8'h66, 8'h6E, 8'h72, 8'h74: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Reference scanner: container kinds in a queue, string context as flags.
    function automatic void ref_model(input byte unsigned f[$], output int err,
                                      output int pos, output int maxd, output int dep);
        bit kinds[$];
        int mode;          // 0 before the root, 1 inside root, 2 after root closed
        bit in_str, esc;
        int hex_left;
        int e;
        byte unsigned c;
        bit ws;
        mode = 0; in_str = 0; esc = 0; hex_left = 0; maxd = 0;
        for (int i = 0; i < f.size(); i++) begin
            c  = f[i];
            ws = (c == 8'h20) || (c == 8'h09) || (c == 8'h0A) || (c == 8'h0D);
            e  = 0;
            if (in_str) begin
                if (hex_left > 0) begin
                    if (is_hex(c)) hex_left--; else e = 6;
                end else if (esc) begin
                    esc = 0;
`ifdef JSON_ESCAPE_CHECK_EN
                    if (c == 8'h75) hex_left = 4;
                    else if (!is_simple_esc(c)) e = 6;
`endif
                end else if (c == 8'h5C) esc = 1;
                else if (c == 8'h22) in_str = 0;
                else if (c < 8'h20) e = 5;
            end else if (mode == 0) begin
                if (c == 8'h7B || c == 8'h5B) begin
                    kinds.push_back(c == 8'h7B);
                    maxd = 1;
                    mode = 1;
                end else if (!ws) e = 7;
            end else if (mode == 1) begin
                if (c == 8'h22) in_str = 1;
                else if (c == 8'h7B || c == 8'h5B) begin
                    if (kinds.size() == MAX_DEPTH) e = 4;
                    else begin
                        kinds.push_back(c == 8'h7B);
                        if (kinds.size() > maxd) maxd = kinds.size();
                    end
                end else if (c == 8'h7D || c == 8'h5D) begin
                    if (kinds[kinds.size()-1] != (c == 8'h7D)) e = 2;
                    else begin
                        void'(kinds.pop_back());
                        if (kinds.size() == 0) mode = 2;
                    end
                end
            end else begin
                if (!ws) e = 3;
            end
            if (e != 0) begin
                err = e; pos = i; dep = kinds.size();
                return;
            end
        end
        err = (mode == 2) ? 0 : 1;
        pos = f.size() - 1;
        dep = kinds.size();
    endfunction

    function automatic byte unsigned noise_byte();
        case ($urandom_range(0, 13))
            0:  return 8'h7B;
            1:  return 8'h7D;
            2:  return 8'h5B;
            3:  return 8'h5D;
            4:  return 8'h22;
            5:  return 8'h5C;
            6:  return 8'h20;
            7:  return 8'h3A;
            8:  return 8'h2C;
            9:  return 8'h31;
            10: return 8'h75;
            11: return 8'h01;
            12: return 8'h0A;
            default: return 8'h78;
        endcase
    endfunction

    function automatic void gen_frame(output byte unsigned f[$]);
        bit st[$];
        bit k;
        int steps;
        string hx = "0123456789aBcDeF";
        f = {};
        if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 16)) f.push_back(noise_byte());
            return;
        end
        if ($urandom_range(0, 1) == 1) f.push_back(8'h20);
        k = 1'($urandom_range(0, 1));
        f.push_back(k ? 8'h7B : 8'h5B);
        st.push_back(k);
        steps = 0;
        while (st.size() > 0 && steps < 24) begin
            steps++;
            case ($urandom_range(0, 6))
                0: begin
                    k = 1'($urandom_range(0, 1));
                    f.push_back(k ? 8'h7B : 8'h5B);
                    st.push_back(k);
                end
                1, 2: begin
                    k = st.pop_back();
                    if ($urandom_range(0, 9) == 0) k = !k;
                    f.push_back(k ? 8'h7D : 8'h5D);
                end
                3: begin
                    f.push_back(8'h22);
                    repeat ($urandom_range(0, 4)) begin
                        case ($urandom_range(0, 9))
                            0: begin f.push_back(8'h5C); f.push_back(8'h6E); end
                            1: begin f.push_back(8'h5C); f.push_back(8'h71); end
                            2: begin
                                f.push_back(8'h5C); f.push_back(8'h75);
                                repeat (4) begin
                                    if ($urandom_range(0, 7) == 0) f.push_back(8'h47);
                                    else f.push_back(hx[$urandom_range(0, 15)]);
                                end
                            end
                            3: f.push_back(8'h01);
                            4: begin f.push_back(8'h5C); f.push_back(8'h22); end
                            default: f.push_back(8'h61);
                        endcase
                    end
                    f.push_back(8'h22);
                end
                4: f.push_back(8'h31);
                5: f.push_back(8'h2C);
                default: f.push_back(8'h3A);
            endcase
        end
        case ($urandom_range(0, 3))
            0: begin f.push_back(8'h20); f.push_back(8'h0D); end
            1: f.push_back(8'h78);
            default: ;
        endcase
    endfunction

    // Drive bytes starting at a falling edge; returns cycles stalled by s_ready=0.
    task automatic send_bytes(input byte unsigned f[$], input bit with_last, output int stalls);
        int tries;
        stalls = 0;
        for (int i = 0; i < f.size(); i++) begin
            s_valid = 1'b1;
            s_data  = f[i];
            s_last  = with_last && (i == f.size() - 1);
            tries   = 0;
            while (!s_ready && tries < 20) begin
                @(negedge clk);
                tries++;
                stalls++;
            end
            if (tries >= 20) check("ready_timeout", 0, 1);
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_frame(input string name, input byte unsigned f[$], input int e_err,
                             input int e_pos, input int e_maxd, input int e_depth, input bit settle);
        int stalls;
        send_bytes(f, 1'b1, stalls);
        exp_pulses++;
        $display("frame %s len=%0d err=%0d pos=%0d maxd=%0d depth=%0d stalls=%0d",
                 name, f.size(), res_err, res_pos, res_max_depth, depth, stalls);
        check({name, ".bubble"},    stalls, pending_bubble ? 1 : 0);
        check({name, ".res_valid"}, int'(res_valid), 1);
        check({name, ".res_err"},   int'(res_err), e_err);
        check({name, ".res_pos"},   int'(res_pos), e_pos);
        check({name, ".max_depth"}, int'(res_max_depth), e_maxd);
        check({name, ".depth"},     int'(depth), e_depth);
        check({name, ".s_ready"},   int'(s_ready), 0);
        if (settle) begin
            @(negedge clk);
            check({name, ".pulse_end"}, int'(res_valid), 0);
            check({name, ".depth_clr"}, int'(depth), 0);
            check({name, ".ready_back"}, int'(s_ready), 1);
            check({name, ".err_hold"},  int'(res_err), e_err);
            pending_bubble = 1'b0;
        end else begin
            pending_bubble = 1'b1;
        end
    endtask

    initial begin
        byte unsigned f[$];
        int e, p, m, d, stalls;
        rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.s_ready",   int'(s_ready), 0);
        check("rst.res_valid", int'(res_valid), 0);
        check("rst.res_err",   int'(res_err), 0);
        check("rst.res_pos",   int'(res_pos), 0);
        check("rst.max_depth", int'(res_max_depth), 0);
        check("rst.depth",     int'(depth), 0);
        rst_n = 1'b1;
        @(negedge clk);

        str2q("{\"a\":[1,2]}", f);  run_frame("nested_ok", f, 0, 10, 2, 0, 1);
        str2q("[1}", f);            run_frame("unexp",     f, 2, 2, 1, 1, 1);
        str2q("{\"x\" ", f);        run_frame("eoi",       f, 1, 4, 1, 1, 1);
        str2q("[[[[[abc", f);       run_frame("overflow",  f, 4, 4, 4, 4, 1);
        str2q("{}  x", f);          run_frame("trailing",  f, 3, 4, 1, 0, 1);
        str2q("  7", f);            run_frame("not_cont",  f, 7, 2, 0, 0, 1);
        f = {8'h5B, 8'h22, 8'h61, 8'h01, 8'h22, 8'h5D};
        run_frame("ctrl_char", f, 5, 3, 1, 1, 1);
`ifdef JSON_ESCAPE_CHECK_EN
        str2q("[\"\\q\"]", f);      run_frame("esc_q",     f, 6, 3, 1, 1, 1);
        str2q("[\"\\u00eG\"]", f);  run_frame("uhex_bad",  f, 6, 7, 1, 1, 1);
`else
        str2q("[\"\\q\"]", f);      run_frame("esc_q",     f, 0, 5, 1, 0, 1);
        str2q("[\"\\u00eG\"]", f);  run_frame("uhex_bad",  f, 0, 9, 1, 0, 1);
`endif
        str2q("[\"\\u00e9\"]", f);  run_frame("uhex_ok",   f, 0, 9, 1, 0, 1);

        // Reset mid-frame discards the frame without a result.
        str2q("{{", f);
        send_bytes(f, 1'b0, stalls);
        check("midrst.depth_before", int'(depth), 2);
        rst_n = 1'b0;
        #1;
        check("midrst.depth", int'(depth), 0);
        check("midrst.res_valid", int'(res_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        str2q("[]", f);             run_frame("after_rst", f, 0, 1, 1, 0, 1);

        // Back-to-back frames with s_valid effectively held high.
        str2q("[]", f);             run_frame("b2b0", f, 0, 1, 1, 0, 0);
        str2q("{}", f);             run_frame("b2b1", f, 0, 1, 1, 0, 0);
        str2q("[1]", f);            run_frame("b2b2", f, 0, 2, 1, 0, 1);

        for (int n = 0; n < 200; n++) begin
            gen_frame(f);
            ref_model(f, e, p, m, d);
            run_frame($sformatf("rnd%0d", n), f, e, p, m, d, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("pulse_count", pulse_cnt, exp_pulses);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
